stream_demux4: RTL
==================

# stream_demux4

Registered 1-to-4 stream demultiplexer: one valid/ready input stream carries a 2-bit destination select, and each accepted word is steered into a one-entry holding register on one of four valid/ready output channels. It is the fan-out companion to the 4:1 selection logic in the datapath, and it lets one producer feed four independently back-pressured consumers. Per-channel transfer counters support debug and verification.

## Interface
- N, default 1: data width of every channel.
- CW, default 8: width of each per-channel transfer counter.
- clk  input  1: clock; all state updates on the rising edge.
- rst  input  1: reset, asynchronous, active-high.
- in_data  input  N: input word.
- in_sel  input  2: destination channel (0..3) for in_data; qualified by in_valid.
- in_valid  input  1: input word and select are valid.
- in_ready  output  1: the block can accept the input this cycle.
- out_data  output  4*N: channel k data at [k*N +: N].
- out_valid  output  4: bit k means channel k holds a word.
- out_ready  input  4: bit k means the consumer of channel k accepts this cycle.
- count  output  4*CW: channel k transfer count at [k*CW +: CW].

## Operation
- Each channel k has a holding register (data plus a valid flag) driving out_data[k] and out_valid[k] directly from flops.
- in_ready = !out_valid[in_sel] | out_ready[in_sel]. This is combinational from in_sel, out_valid and out_ready, and never depends on in_valid.
- Accept: in_valid & in_ready at a rising edge loads in_data into channel in_sel and sets out_valid[in_sel].
- Drain: out_valid[k] & out_ready[k] at an edge, with no load into k, clears out_valid[k]. Data is not cleared.
- Simultaneous drain and load on the same channel: the new word loads and out_valid stays 1, giving full throughput of one word per cycle per channel.
- Load into channel a and drain of a different channel b in the same edge: both occur independently.
- While out_valid[k] & !out_ready[k], out_data[k] holds stable.
- When in_valid=0, in_sel is don't-care. No state changes from the input side, and in_ready may still toggle with in_sel.
- Only one channel can be loaded per cycle. The other three channels only drain or hold.
- Counters: count[k] increments by 1 on each accepted input with in_sel=k, at the accept edge. It wraps from 2^CW-1 to 0 with no saturation and no flag.
- X on in_sel while in_valid=0 causes no state change.

## Timing
- Reset values: out_valid=4'b0000, out_data all 0, count all 0. in_ready is therefore 1 during and after reset, for any in_sel.
- Asserting rst mid-operation discards every held word immediately (asynchronously). Counters clear.
- Latency: a word accepted at edge t is visible on out_data[k] with out_valid[k]=1 from just after edge t. It is consumed at the first edge ≥ t+1 at which out_ready[k]=1.
- Back-pressure: channel k full with out_ready[k]=0 gives in_ready=0 whenever in_sel=k. Traffic to other, non-full channels still flows.
- There is no ordering guarantee across channels. Order is preserved within each channel.

## Test plan
- Reset then idle: rst pulse with all out_ready=1 -> out_valid=0000, count all 0, in_ready=1 for every in_sel.
- Route one word per channel (N=8): send 0xA0,0xA1,0xA2,0xA3 to sel 0,1,2,3 on consecutive cycles with out_ready=0000 -> out_valid=1111, out_data={A3,A2,A1,A0}, each count=1. Then in_sel=2 with in_valid=1 -> in_ready=0.
- Full-rate streaming: out_ready[1]=1, send 0x10..0x1F to sel 1 on 16 back-to-back cycles -> in_ready stays 1 throughout, consumer sees 0x10..0x1F in order with no gaps, count[1]=16.
- Stall and release: channel 3 holds 0x55 with out_ready[3]=0 for 5 cycles -> out_data[3]=0x55 stable, in_ready=0 for sel 3. Set out_ready[3]=1 while driving 0x66 -> 0x55 is consumed and 0x66 loads on the same edge.
- Counter wrap (CW=4): 17 accepts to channel 0 -> count[0]=1, other counts 0.
- Reset mid-flight: channels 0 and 2 full, assert rst asynchronously between edges -> out_valid=0000 and counts 0 immediately. After rst deasserts, the next accept to channel 2 behaves normally.

Source files
------------

// File: rtl/stream_demux4.sv
// Registered 1-to-4 valid/ready stream demultiplexer.
// Each output channel has a one-entry holding register and a transfer counter.
module stream_demux4 #(
    parameter int N  = 1,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_data,
    input  logic [1:0]      in_sel,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [4*N-1:0]  out_data,
    output logic [3:0]      out_valid,
    input  logic [3:0]      out_ready,
    output logic [4*CW-1:0] count
);

    logic       accept;
    logic [3:0] load;

    // Selected channel can take a word if empty or draining this cycle
    always_comb begin
        in_ready = !out_valid[in_sel] | out_ready[in_sel];
        accept   = in_valid & in_ready;
        load     = 4'b0000;
        if (accept) begin
            load[in_sel] = 1'b1;
        end
    end

    // Holding registers: load wins over drain so a channel streams at full rate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 4'b0000;
            out_data  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    out_data[k*N +: N] <= in_data;
                    out_valid[k]       <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Per-channel accept counters, free-running wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    count[k*CW +: CW] <= count[k*CW +: CW] + CW'(1);
                end
            end
        end
    end

endmodule
